// File: rtl/siso_pkg.sv
// Shared definitions for the serial-in/serial-out sequencer: state codes and
// the sizing rule for the transfer counter.
package siso_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_DONE  = 2'd2;

   // The counter must reach WIDTH+DEPTH-1 without wrapping.
   function automatic int cnt_width(input int width, input int depth);
      return $clog2(width + depth + 1);
   endfunction

endpackage

// File: rtl/siso_chain.sv
// DEPTH-stage enabled shift chain: d enters stage 0, q is the last stage.
// Every stage holds its value while en is low.
module siso_chain
   import siso_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d,
   output logic q
);

   logic [DEPTH:0] tap;

   assign tap[0] = d;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic stage_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               stage_reg <= 1'b0;
            end else if (en) begin
               stage_reg <= tap[gi];
            end
         end

         assign tap[gi+1] = stage_reg;
      end
   endgenerate

   assign q = tap[DEPTH];

endmodule

// File: rtl/siso_seq_ctrl.sv
// Loopback sequencer: serialises a word LSB-first through a DEPTH-stage chain,
// flushes the chain latency and reassembles the word at the chain tail.
module siso_seq_ctrl
   import siso_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             ser_out
);

   localparam int CNT_W = cnt_width(WIDTH, DEPTH);
   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH + DEPTH - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] tx_reg;
   logic [WIDTH-1:0] rx_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             sh_en;
   logic [WIDTH-1:0] rx_next;

   assign sh_en = (state_reg == ST_SHIFT);

   // Written without a part-select so WIDTH=1 stays legal.
   assign rx_next = (rx_reg >> 1) | (WIDTH'(ser_out) << (WIDTH - 1));

   siso_chain #(
      .DEPTH (DEPTH)
   ) u_chain (
      .clk (clk),
      .rst (rst),
      .en  (sh_en),
      .d   (tx_reg[0]),
      .q   (ser_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         tx_reg    <= '0;
         rx_reg    <= '0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  tx_reg    <= in_data;
                  rx_reg    <= '0;
                  cnt_reg   <= '0;
                  state_reg <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Zero fill behind the word flushes the chain by the end of SHIFT.
               tx_reg  <= tx_reg >> 1;
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (cnt_reg >= CNT_FIRST) begin
                  rx_reg <= rx_next;
               end
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign busy      = (state_reg != ST_IDLE);
   assign out_data  = rx_reg;

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// Bench for siso_seq_ctrl: a word-level model (queue of words in flight plus
// their age in cycles) predicts every handshake output, data and tail bit.
module tb_siso_seq_ctrl;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         busy;
   logic         ser_out;

   logic         in_valid_b = 1'b0;
   logic         in_ready_b;
   logic [0:0]   in_data_b = '0;
   logic         out_valid_b;
   logic         out_ready_b = 1'b1;
   logic [0:0]   out_data_b;
   logic         busy_b;
   logic         ser_out_b;

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   int accepted = 0;
   int delivered = 0;
   int age = 0;
   logic [W-1:0] q[$];
   int           q_acc_cycle[$];

   siso_seq_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .ser_out   (ser_out)
   );

   siso_seq_ctrl #(.WIDTH(1), .DEPTH(1)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .in_data   (in_data_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .out_data  (out_data_b),
      .busy      (busy_b),
      .ser_out   (ser_out_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_out_valid();
      return (q.size() != 0) && (age >= W + D);
   endfunction

   // Tail bit: word bit i appears when the word is D+i cycles old; otherwise
   // the chain only ever holds flushed zeros.
   function automatic logic model_ser();
      logic [W-1:0] w;
      if (q.size() != 0 && age >= D && age < D + W) begin
         w = q[0];
         return w[age - D];
      end
      return 1'b0;
   endfunction

   // Check current outputs against the model, then advance one clock.
   task automatic tick();
      logic         acc;
      logic         dlv;
      logic [W-1:0] word;
      int           lat;
      chk("in_ready", in_ready, q.size() == 0);
      chk("busy", busy, q.size() != 0);
      chk("out_valid", out_valid, model_out_valid());
      chk("ser_out", ser_out, model_ser());
      if (model_out_valid()) chk("out_data", out_data, q[0]);
      acc  = in_valid && (q.size() == 0);
      dlv  = model_out_valid() && out_ready;
      word = in_data;
      @(posedge clk);
      #1;
      cycle++;
      if (dlv) begin
         lat = cycle - 1 - q_acc_cycle[0];
         $display("xfer %0d: data=%02h latency=%0d", delivered, q[0], lat);
         void'(q.pop_front());
         void'(q_acc_cycle.pop_front());
         delivered++;
      end
      if (acc) begin
         q.push_back(word);
         q_acc_cycle.push_back(cycle);
         age = 0;
         accepted++;
      end else if (q.size() != 0) begin
         age++;
      end
   endtask

   initial begin
      int acc_cyc[3];
      logic [W-1:0] b2b[3];
      int base;
      int target;
      int n;

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ser_out", ser_out, 0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // Single transfer 0xA5, consumer ready only after completion
      in_valid = 1'b1;
      in_data  = 8'hA5;
      tick();
      in_valid = 1'b0;
      chk("a5_busy_e0", busy, 1);
      chk("a5_in_ready_e0", in_ready, 0);
      for (int i = 0; i < 11; i++) tick();
      chk("a5_out_valid_e11", out_valid, 0);
      tick();
      chk("a5_out_valid_e12", out_valid, 1);
      chk("a5_out_data", out_data, 8'hA5);
      tick();
      out_ready = 1'b1;
      tick();
      chk("a5_delivered", delivered, 1);

      // Backpressure with ignored in_valid pulses
      in_valid = 1'b1;
      in_data  = 8'h81;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0];
         in_data  = 8'hFF;
         tick();
         chk("bp_out_data", out_data, 8'h81);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("bp_delivered", delivered, 2);
      chk("bp_accepted", accepted, 2);

      // Back-to-back with in_valid held high
      b2b[0] = 8'h00;
      b2b[1] = 8'hFF;
      b2b[2] = 8'h5A;
      base = delivered;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data = b2b[k];
         n = accepted;
         for (int t = 0; t < 40 && accepted == n; t++) tick();
         chk("b2b_accept", accepted, n + 1);
         acc_cyc[k] = cycle;
      end
      in_valid = 1'b0;
      for (int t = 0; t < 40 && delivered < base + 3; t++) tick();
      chk("b2b_delivered", delivered, base + 3);
      chk("b2b_period_1", acc_cyc[1] - acc_cyc[0], 14);
      chk("b2b_period_2", acc_cyc[2] - acc_cyc[1], 14);

      // Asynchronous reset in the middle of shifting 0x3C
      in_valid = 1'b1;
      in_data  = 8'h3C;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b0;
      #1;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ser_out", ser_out, 0);
      q.delete();
      q_acc_cycle.delete();
      age = 0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      cycle += 2;
      n = delivered;
      for (int i = 0; i < 20; i++) tick();
      chk("arst_no_emit", delivered, n);

      // Boundary instance WIDTH=1, DEPTH=1
      in_valid_b = 1'b1;
      in_data_b  = 1'b1;
      tick();
      in_valid_b = 1'b0;
      chk("b1_busy_e0", busy_b, 1);
      chk("b1_out_valid_e0", out_valid_b, 0);
      tick();
      chk("b1_out_valid_e1", out_valid_b, 0);
      chk("b1_ser_out_e1", ser_out_b, 1);
      tick();
      chk("b1_out_valid_e2", out_valid_b, 1);
      chk("b1_out_data", out_data_b, 1);
      $display("xfer b: data=1 latency=2");
      tick();
      chk("b1_idle", in_ready_b, 1);
      in_valid_b = 1'b1;
      in_data_b  = 1'b0;
      tick();
      in_valid_b = 1'b0;
      tick();
      tick();
      chk("b0_out_valid_e2", out_valid_b, 1);
      chk("b0_out_data", out_data_b, 0);
      $display("xfer b: data=0 latency=2");
      tick();

      // Random regression with consumer stalls
      target = delivered + 1000;
      for (int c = 0; c < 60000 && delivered < target; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = W'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      chk("rand_delivered", delivered, target);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/siso_seq_ctrl.md
Name: siso_seq_ctrl

Overview:
- Sequencer for a DEPTH-stage serial-in/serial-out shift chain.
- Accepts a parallel WIDTH-bit word on a valid/ready handshake and serialises it LSB-first into the chain.
- Drives the chain's shift enable, flushes the chain's latency, and reassembles the serial output into a parallel word, presented on a second valid/ready handshake.
- Used as the loopback/self-test front end for the shift-register library; out_data must equal in_data for every transfer.

Parameters:
- WIDTH, 8, bits per transferred word (>=1).
- DEPTH, 4, number of stages in the controlled shift chain (>=1).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  in_data is valid.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  word to serialise.
- out_valid  output  1  out_data holds a completed word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  reassembled word.
- busy  output  1  state != IDLE.
- ser_out  output  1  chain tail bit, for observation only.

Behaviour:
- States: IDLE, SHIFT, DONE. Encoding is binary, 2 bits.
- Reset (rst=0, asynchronous):
  - state=IDLE, tx_reg=0, rx_reg=0, cnt=0, all chain stages=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0, ser_out=0.
  - Reset mid-transfer discards the word; nothing is emitted.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE). All three decode from registered state.
- IDLE:
  - On a clock edge with in_valid=1: tx_reg<=in_data, cnt<=0, rx_reg<=0, state<=SHIFT.
  - in_data is sampled only at this edge.
- SHIFT, every cycle:
  - sh_en=1 to the chain.
  - Chain serial input = tx_reg[0]; tx_reg shifts right with zero fill, so zeros follow the word.
  - cnt<=cnt+1.
- Capture in SHIFT:
  - When cnt>=DEPTH, rx_reg<={ser_out, rx_reg[WIDTH-1:1]} (LSB-first reassembly).
  - The chain tail sampled before the edge with cnt=DEPTH+i carries word bit i.
- Leaving SHIFT:
  - At the edge where cnt==WIDTH+DEPTH-1, after the final capture: state<=DONE.
  - SHIFT therefore lasts exactly WIDTH+DEPTH cycles.
- cnt width is $clog2(WIDTH+DEPTH+1). cnt never wraps during a transfer.
- DONE:
  - out_data=rx_reg, held stable while out_ready=0; the chain is frozen (sh_en=0).
  - On an edge with out_ready=1: state<=IDLE.
  - At least one IDLE cycle always separates transfers.
- Latency: the accepting edge is E0. out_valid is 1 from edge E0+WIDTH+DEPTH onward.
- Ignored inputs:
  - in_valid during SHIFT or DONE has no effect (in_ready=0).
  - out_ready in IDLE or SHIFT has no effect.
- Chain stages hold their value whenever sh_en=0.
- At the end of SHIFT the chain holds zeros (the flushed fill bits).

Decomposition:
- Shared package siso_pkg holds:
  - state typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - localparam helper for counter width.
- Sub-module siso_chain (params DEPTH; ports clk, rst, en, d, q) holds the enabled shift chain.
  - Reset is asynchronous active-low, clearing all stages.
  - Instantiated once; the controller keeps FSM, tx_reg, rx_reg and cnt.

Test Plan:
- Reset: drive rst=0 mid-SHIFT of word 0x3C -> all outputs go to reset values immediately (asynchronously), in_ready=1, out_valid never rises for 0x3C.
- Single transfer (WIDTH=8, DEPTH=4), in_data=0xA5 accepted at E0 -> busy=1, in_ready=0 from E0, out_valid=1 at E0+12, out_data=0xA5.
- Backpressure: in_data=0x81, hold out_ready=0 for 20 cycles -> out_data stays 0x81 and out_valid stays 1; ser_out=0; in_valid pulses with 0xFF are ignored; release out_ready -> IDLE next edge.
- Back-to-back: in_valid held high with 0x00, then 0xFF, then 0x5A, out_ready=1 -> three words returned in order with exact values, each period = 1 + 12 + 1 cycles (accept, shift, done).
- Boundary params WIDTH=1, DEPTH=1: in_data=1 -> out_valid at E0+2, out_data=1; in_data=0 -> out_data=0.
- Random regression: 1000 random words with random out_ready stalls -> out_data==in_data for every word, no drops or duplicates.
